// File: rtl/mult_seq.sv
// Multi-cycle WIDTH x WIDTH multiplier: one WIDTH x DIGIT partial product per cycle, with
// valid/ready handshakes on input and output. Define MULT_SEQ_SIGNED_EN to add the sgn port.
module mult_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SEQ_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LastK = KW'(N - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [KW-1:0]      k_q, k_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_in;
  logic [31:0]        shamt;
  logic [WIDTH-1:0]   b_shift;
  logic [DIGIT-1:0]   b_digit;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] sum;

  // The core always works on magnitudes; the sign is reapplied when the product is loaded.
`ifdef MULT_SEQ_SIGNED_EN
  assign a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
  assign neg_in = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign neg_in = 1'b0;
`endif

  always_comb begin
    shamt   = 32'(k_q) * DIGIT;
    b_shift = b_q >> shamt;
    b_digit = b_shift[DIGIT-1:0];
    pp      = ({{WIDTH{1'b0}}, a_q} * {{(2*WIDTH-DIGIT){1'b0}}, b_digit}) << shamt;
    sum     = acc_q + pp;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    k_d     = k_q;
    neg_d   = neg_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = neg_in;
          acc_d   = '0;
          k_d     = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = sum;
        k_d   = k_q + KW'(1);
        if (k_q == LastK) begin
          p_d     = neg_q ? -sum : sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      k_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      k_q     <= k_d;
      neg_q   <= neg_d;
    end
  end

  // in_ready is held low during the reset cycle itself.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign p         = p_q;

endmodule
